// File: rtl/aes_pkg.sv
// Shared AES types and round helpers: column-major 4x4 byte state, GF(2^8) xtime,
// MixColumns, ShiftRows, FSM encodings and round-count constants.
package aes_pkg;

  localparam int NR128 = 10;
  localparam int NR192 = 12;
  localparam int NR256 = 14;

  localparam int ROUND_KEY_W = 128;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // st[c][r] holds input byte 4*c+r, so a flat [0:127] block casts straight in.
  typedef logic [0:3][7:0]       col_t;
  typedef logic [0:3][0:3][7:0]  state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic col_t mix_column(input col_t a);
    col_t m;
    m[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
    m[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
    m[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
    m[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
    return m;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++) o[c] = mix_column(s[c]);
    return o;
  endfunction

  function automatic state_t shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = s[(c + r) % 4][r];
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; table row n holds outputs for inputs n0..nf.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] s
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = SBOX[{x, 3'b000} +: 8];

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor, one round per clock: accept -> out_valid after Nr edges.
// Single block in flight; DONE holds the ciphertext until out_ready, in_ready low meanwhile.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nr = NR128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             in_data,
  input  logic [0:32*(4*Nr+4)-1]   w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             out_data
);

  localparam int         W_BITS   = 32 * (4 * Nr + 4);
  localparam int         IW       = $clog2(W_BITS);
  localparam logic [3:0] LAST_RND = 4'(Nr);

  logic [1:0]    fsm;
  logic [3:0]    rnd;
  logic          live;
  state_t        st;
  logic [0:127]  st_flat;
  logic [0:127]  sub_flat;
  state_t        shifted;
  state_t        mixed;
  state_t        nxt;
  logic [IW-1:0] key_base;
  logic [0:127]  rkey;

  assign st_flat = st;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (
      .x (st_flat[8*i +: 8]),
      .s (sub_flat[8*i +: 8])
    );
  end

  assign key_base = IW'({rnd, 7'b0000000});
  assign rkey     = w[key_base +: ROUND_KEY_W];

  always_comb begin
    shifted = shift_rows(state_t'(sub_flat));
    mixed   = mix_columns(shifted);
    // The final round drops MixColumns.
    nxt     = (rnd == LAST_RND) ? (shifted ^ rkey) : (mixed ^ rkey);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm  <= IDLE;
      rnd  <= 4'd0;
      st   <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            st  <= in_data ^ w[0:ROUND_KEY_W-1];
            rnd <= 4'd1;
            fsm <= RUN;
          end
        end
        RUN: begin
          st <= nxt;
          if (rnd == LAST_RND) fsm <= DONE;
          else                 rnd <= rnd + 4'd1;
        end
        DONE: begin
          if (out_ready) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // live keeps in_ready low until the first edge after reset release.
  assign in_ready  = live && (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign out_data  = st;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: FIPS-197 vectors, handshake/latency/reset corner cases and random blocks
// against a byte-array AES model with an S-box derived from GF(2^8) inversion.
module tb_aes_cipher_iter;
  import aes_pkg::*;

  localparam int W10 = 32 * (4 * NR128 + 4);
  localparam int W14 = 32 * (4 * NR256 + 4);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid10, in_valid14;
  logic            in_ready10, in_ready14;
  logic [0:127]    in_data;
  logic [0:W10-1]  w10;
  logic [0:W14-1]  w14;
  logic            out_valid10, out_valid14;
  logic            out_ready;
  logic [0:127]    out_data10, out_data14;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sb [256];
  logic [7:0] ks [240];

  aes_cipher_iter #(.Nr(NR128)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10), .in_data(in_data),
    .w(w10), .out_valid(out_valid10), .out_ready(out_ready), .out_data(out_data10)
  );

  aes_cipher_iter #(.Nr(NR256)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14), .in_data(in_data),
    .w(w14), .out_valid(out_valid14), .out_ready(out_ready), .out_data(out_data14)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [0:255] key, input int nk, input int nr);
    logic [7:0] t [4];
    logic [7:0] u [4];
    logic [7:0] rc;
    int nw;
    rc = 8'h01;
    nw = 4 * (nr + 1);
    for (int i = 0; i < 4 * nk; i++) ks[i] = key[8*i +: 8];
    for (int i = nk; i < nw; i++) begin
      for (int j = 0; j < 4; j++) t[j] = ks[4*(i-1)+j];
      if (i % nk == 0) begin
        u[0] = sb[t[1]] ^ rc; u[1] = sb[t[2]]; u[2] = sb[t[3]]; u[3] = sb[t[0]];
        for (int j = 0; j < 4; j++) t[j] = u[j];
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
      end
      for (int j = 0; j < 4; j++) ks[4*i+j] = ks[4*(i-nk)+j] ^ t[j];
    end
  endtask

  function automatic logic [0:127] ref_enc(input logic [0:127] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [0:127] res;
    for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ ks[n];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int n = 0; n < 16; n++) s[n] = sb[s[n]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      if (rd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = t[n] ^ ks[16*rd+n];
    end
    for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
    return res;
  endfunction

  task automatic load10();
    w10 = '0;
    for (int i = 0; i < 16 * (NR128 + 1); i++) w10[8*i +: 8] = ks[i];
  endtask

  task automatic load14();
    w14 = '0;
    for (int i = 0; i < 16 * (NR256 + 1); i++) w14[8*i +: 8] = ks[i];
  endtask

  // ---------------- DUT access helpers ----------------
  function automatic logic rdy(input int s);
    return (s != 0) ? in_ready14 : in_ready10;
  endfunction

  function automatic logic ov(input int s);
    return (s != 0) ? out_valid14 : out_valid10;
  endfunction

  function automatic logic [0:127] od(input int s);
    return (s != 0) ? out_data14 : out_data10;
  endfunction

  task automatic set_valid(input int s, input logic v);
    if (s != 0) in_valid14 = v;
    else        in_valid10 = v;
  endtask

  // Offers pt, waits for the accept edge, then waits for out_valid; returns at a negedge.
  task automatic drive_block(input int s, input logic [0:127] pt, input bit poke,
                             input logic [0:127] intr, output logic [0:127] ct,
                             output int acc, output int lat);
    int n;
    in_data = pt;
    set_valid(s, 1'b1);
    n = 0;
    @(negedge clk);
    while (!rdy(s) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(s)) begin
      check("accept_timeout", rdy(s), 1);
      set_valid(s, 1'b0);
      ct = '0; acc = cyc; lat = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    set_valid(s, 1'b0);
    n = 0;
    @(negedge clk);
    while (!ov(s) && n < 100) begin
      if (poke && n == 2) begin
        in_data = intr;
        set_valid(s, 1'b1);
      end
      if (poke && n == 4) set_valid(s, 1'b0);
      @(negedge clk);
      n++;
    end
    set_valid(s, 1'b0);
    if (!ov(s)) check("out_valid_timeout", ov(s), 1);
    lat = cyc - acc;
    ct = od(s);
  endtask

  task automatic complete_xfer();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [0:127] ct, ct_bp, pt, exp;
    logic [0:255] key;
    int acc, acc2, lat;
    bit seen;

    rst = 1'b1; in_valid10 = 1'b0; in_valid14 = 1'b0; out_ready = 1'b1;
    in_data = '0; w10 = '0; w14 = '0;
    build_sbox();

    #12;
    check("rst_in_ready", in_ready10, 0);
    check("rst_out_valid", out_valid10, 0);
    check("rst_out_data", out_data10, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("in_ready_before_edge", in_ready10, 0);
    @(negedge clk);
    check("in_ready_after_edge", in_ready10, 1);

    // FIPS-197 App. B
    expand({KEY_B, 128'h0}, 4, NR128);
    load10();
    drive_block(0, PT_B, 0, '0, ct, acc, lat);
    check("appb_ct", ct, CT_B);
    check("appb_latency", lat, NR128);
    complete_xfer();

    // zero key/pt, then App. C.1 back to back
    expand('0, 4, NR128);
    load10();
    drive_block(0, '0, 0, '0, ct, acc, lat);
    check("zero_ct", ct, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    complete_xfer();
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NR128);
    load10();
    drive_block(0, PT_C, 0, '0, ct, acc2, lat);
    check("c1_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("b2b_accept_spacing", acc2 - acc, NR128 + 2);
    complete_xfer();

    // App. C.3 on the 14-round instance
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, NR256);
    load14();
    drive_block(1, PT_C, 0, '0, ct, acc, lat);
    check("c3_ct", ct, 128'h8ea2b7ca516745bfeafc49904b496089);
    check("c3_latency", lat, NR256);
    complete_xfer();

    // Backpressure: hold DONE for 20 cycles
    expand({KEY_B, 128'h0}, 4, NR128);
    load10();
    out_ready = 1'b0;
    drive_block(0, PT_B, 0, '0, ct_bp, acc, lat);
    check("bp_ct", ct_bp, CT_B);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_data_stable", out_data10, ct_bp);
      check("bp_in_ready_low", in_ready10, 0);
      check("bp_valid_held", out_valid10, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", out_valid10, 0);
    check("bp_release_in_ready", in_ready10, 1);

    // in_valid pulsed during RUN with a different block
    pt = {$urandom, $urandom, $urandom, $urandom};
    drive_block(0, PT_B, 1, pt, ct, acc, lat);
    check("intruder_ignored_ct", ct, CT_B);
    complete_xfer();

    // Reset in round 5
    in_data = PT_B;
    set_valid(0, 1'b1);
    @(negedge clk);
    check("pre_rst_ready", in_ready10, 1);
    @(posedge clk);
    #1;
    set_valid(0, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid10, 0);
    check("async_rst_in_ready", in_ready10, 0);
    check("async_rst_data", out_data10, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (NR128 + 4) begin
      @(negedge clk);
      if (out_valid10) seen = 1'b1;
    end
    check("no_out_valid_after_rst", seen, 0);
    pt = {$urandom, $urandom, $urandom, $urandom};
    drive_block(0, pt, 0, '0, ct, acc, lat);
    check("post_rst_ct", ct, ref_enc(pt, NR128));
    complete_xfer();

    // Random keys and blocks with random output stalls
    for (int k = 0; k < 12; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand(key, 4, NR128);
      load10();
      exp = ref_enc(pt, NR128);
      out_ready = 1'($urandom_range(0, 1));
      drive_block(0, pt, 0, '0, ct, acc, lat);
      check("rand_ct", ct, exp);
      check("rand_latency", lat, NR128);
      if (!out_ready) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("rand_stall_data", out_data10, exp);
      end
      complete_xfer();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_cipher_iter.md
Name: aes_cipher_iter

Overview:
- Iterative AES encryption core; one round per clock.
- Sits directly downstream of keyexpansion and consumes its full expanded-key vector w.
- Takes one 128-bit plaintext block per valid/ready transaction and returns one ciphertext block per transaction.
- Supports AES-128/192/256 through Nr; key width is irrelevant here because only w is used.

Parameters:
- Nr, 10, number of rounds (10 → AES-128, 12 → AES-192, 14 → AES-256); w width = 32*(4*Nr+4).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  plaintext block valid.
- in_ready  output  1  core idle and able to accept.
- in_data  input  [0:127]  plaintext, byte 0 = bits 0:7 (FIPS-197 order).
- w  input  [0:32*(4*Nr+4)-1]  expanded key; round key i = w[128*i +: 128].
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  consumer accepts ciphertext.
- out_data  output  [0:127]  ciphertext, same byte order.

Behaviour:
- Reset is asynchronous, active-high: state=IDLE, round counter=0, state register=0, in_ready=0 while rst is high and 1 from the first edge after release; out_valid=0, out_data=0.
- Three-state FSM:
  - IDLE: in_ready=1. On the edge where in_valid&in_ready: state_reg ← in_data ^ w[0:127], rnd ← 1, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge applies SubBytes → ShiftRows → MixColumns → AddRoundKey(w[128*rnd +:128]) and increments rnd.
  - On rnd==Nr, MixColumns is skipped, the result goes to state_reg, then go to DONE.
  - DONE: out_valid=1, out_data=state_reg, held stable until out_valid&out_ready; on that edge go to IDLE.
- Latency: acceptance edge t0 → out_valid high after edge t0+Nr, i.e. Nr+1 cycles from the accept cycle; out_data is combinational from state_reg.
- Throughput: one block per Nr+2 cycles with out_ready tied high.
  - in_ready is low in DONE; no overlap of output handshake with a new accept.
- in_valid while in_ready=0 is ignored; no buffering, so the producer must hold.
- w is not registered. It must be stable from the accept edge until the out_valid&out_ready edge; the bench and integrators guarantee this.
- Backpressure: out_ready low in DONE stalls indefinitely with data unchanged.
- rst asserted mid-RUN or mid-DONE: immediate return to IDLE, the block in flight is discarded, and no out_valid pulse follows.
- rnd is a 4-bit counter, range 1..Nr; no wrap.
- MixColumns uses xtime over GF(2^8) with polynomial 0x11B:
  - xtime(b) = {b[1:7],0} ^ (b[0] ? 8'h1B : 0).
- ShiftRows: row r rotated left by r over the column-major state, bytes indexed as in FIPS-197.

Decomposition:
- Shared package aes_pkg:
  - state type (4x4 bytes);
  - xtime / mix_column / shift_rows functions;
  - round-key slice width constant 128;
  - FSM state enum {IDLE, RUN, DONE};
  - Nr constants NR128/NR192/NR256 = 10/12/14.
- One sub-module: aes_sbox (8-bit in → 8-bit out, combinational forward S-box). It is instantiated 16 times for SubBytes and is the same S-box keyexpansion needs.

Test Plan:
- FIPS-197 App. B: w from keyexpansion(key 2b7e151628aed2a6abf7158809cf4f3c), Nr=10, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32, out_valid exactly 11 cycles after the accept cycle.
- Zero key, zero pt (Nr=10) → 66e94bd4ef8a2c3b884cfa59ca342b2e; then App. C.1 key 000102…0f, pt 00112233…ff sent back-to-back with out_ready=1 → 69c4e0d86a7b0430d8cdb78070b4c55a, second accept exactly 12 cycles after the first.
- Nr=14 build, App. C.3 key 000102…1f, pt 00112233…ff → 8ea2b7ca516745bfeafc49904b496089.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_data constant, in_ready=0 throughout; release → one transfer, then in_ready=1 next cycle.
- in_valid pulsed with a different pt during RUN → ignored; ct matches the first block only.
- rst pulsed at round 5 → outputs return to reset values asynchronously, no out_valid; next block after reset yields correct ct.
